countdown_yi_v1: RTL and testbench
==================================

// Module: countdown_yi_v1
// PURPOSE
//  Loadable down-counter that consumes a count length and reports completion.
//  Counterpart of the free-running up-counter: an upstream controller hands over a length
//  (valid/ready), the block counts it down while enable is high, then pulses done once.
//  Used as a loop/tile terminator in the controller datapath; enable low stalls it.
// PARAMETERS
//  BITS_OF_END_NUMBER  20  width of load_number and cnt_q
// PORTS
//  clk          in   1     clock, all state on posedge
//  reset        in   1     asynchronous, active-high reset
//  load_valid   in   1     upstream presents load_number
//  load_ready   out  1     block can accept a load (state IDLE)
//  load_number  in   N     count length, N = BITS_OF_END_NUMBER, unsigned
//  enable       in   1     1 = count this cycle, 0 = stall (hold cnt_q)
//  abort        in   1     cancel a run in progress
//  cnt_q        out  N     remaining count minus one during RUN, 0 in IDLE
//  busy         out  1     1 while in RUN
//  done         out  1     registered one-cycle completion pulse
// BEHAVIOUR
//  - Reset (async, active-high): state=IDLE, cnt_q=0, busy=0, done=0; load_ready=1 after reset.
//  - FSM states: IDLE, RUN. load_ready = (state==IDLE); busy = (state==RUN), both from state reg.
//  - IDLE: accept when load_valid && load_ready at edge E0.
//      load_number>0: cnt_q<=load_number-1, state<=RUN (busy=1 after E0).
//      load_number==0: no RUN; done=1 for the cycle after E0; cnt_q stays 0.
//      abort and enable ignored in IDLE.
//  - RUN, per edge, priority order:
//      1. abort=1: state<=IDLE, cnt_q<=0, no done pulse (even if terminal count same cycle).
//      2. enable=0: hold cnt_q and state.
//      3. enable=1, cnt_q!=0: cnt_q<=cnt_q-1.
//      4. enable=1, cnt_q==0: terminal; done<=1 next cycle, state<=IDLE, cnt_q stays 0.
//  - Latency: load N>0 with enable held high -> done high in cycle after edge E0+N
//    (exactly N enabled edges after accept); load_ready high in same cycle as done.
//  - load_valid while busy: ignored, not queued; upstream must hold until load_ready.
//  - done default 0 every cycle unless set by a terminal/zero-load event; never 2 cycles wide
//    (exception: auto-reload with N=1 and enable held, see below).
//  - Arithmetic unsigned, N bits; decrement never wraps below 0 (terminal handled first).
//  - Max length 2^N-1. Reset mid-run: immediate return to reset values, pending done lost.
// CONFIGURATION
//  Macro COUNTDOWN_AUTO_RELOAD_EN:
//  - Defined: accepted load_number stored in reload register (reset 0). Terminal in RUN
//    reloads cnt_q<=reload-1, pulses done, stays in RUN (busy stays 1, load_ready stays 0);
//    run ends only via abort or reset. N=1 with enable held: done high every cycle.
//    load_number==0 still completes immediately from IDLE, no RUN.
//  - Undefined: no reload register; terminal returns to IDLE as above.
// TESTING
//  T1 reset, load 5, enable=1 -> cnt_q 4,3,2,1,0; done 1 cycle after 5th enabled edge; busy 0.
//  T2 load 4, enable 1,0,0,1,1,1 -> cnt_q holds during stall; done delayed by 2 cycles.
//  T3 load 0 in IDLE -> done pulse next cycle, busy never 1, cnt_q=0, load_ready stays 1.
//  T4 load 6, abort at cnt_q=2 with enable=1 -> IDLE, cnt_q=0, no done ever.
//  T5 load 3, load_valid=1 (load_number=9) throughout RUN -> ignored; after done, 9 accepted.
//  T6 COUNTDOWN_AUTO_RELOAD_EN, load 3, enable=1 -> cnt_q 2,1,0,2,1,0..., done every 3rd cycle;
//     abort -> IDLE; reset mid-run -> all outputs 0, load_ready 1.

Source files
------------

// File: rtl/countdown_yi_v1.sv
// -----------------------------------------------------------------------------
// countdown_yi_v1
//
// Purpose:
//   Loadable down-counter that terminates loops or tiles in the controller
//   datapath. An upstream controller hands over a count length through a
//   valid/ready handshake. The block counts that length down on cycles where
//   enable is high. It then raises done for exactly one cycle.
//
// Configuration macro:
//   COUNTDOWN_AUTO_RELOAD_EN
//     - Undefined (default): reaching the terminal count returns the block to
//       IDLE.
//     - Defined: the accepted length is stored. Reaching the terminal count
//       reloads from the stored length, pulses done, and keeps running. A run
//       then ends only through abort or reset.
//
// Ports:
//   clk          in   1  clock, all state updates on the rising edge
//   reset        in   1  asynchronous reset, active high
//   load_valid   in   1  upstream presents load_number
//   load_ready   out  1  block can accept a load (IDLE)
//   load_number  in   N  count length, unsigned
//   enable       in   1  1 = count this cycle, 0 = stall
//   abort        in   1  cancel the run in progress (ignored in IDLE)
//   cnt_q        out  N  remaining count minus one while running, 0 in IDLE
//   busy         out  1  high while running
//   done         out  1  registered one-cycle completion pulse
// -----------------------------------------------------------------------------
module countdown_yi_v1 #(
    parameter int BITS_OF_END_NUMBER = 20
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [BITS_OF_END_NUMBER-1:0] load_number,
    input  logic                          enable,
    input  logic                          abort,
    output logic [BITS_OF_END_NUMBER-1:0] cnt_q,
    output logic                          busy,
    output logic                          done
);

    localparam int N = BITS_OF_END_NUMBER;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] ZERO = '0;

    logic         state_q, state_d;
    logic [N-1:0] cnt_d;
    logic         done_q, done_d;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [N-1:0] reload_q, reload_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        reload_d = reload_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // In IDLE, load_ready equals 1, so load_valid alone completes the handshake.
                if (load_valid) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                    reload_d = load_number;
`endif
                    if (load_number != ZERO) begin
                        cnt_d   = load_number - ONE;
                        state_d = ST_RUN;
                    end else begin
                        // A zero-length load completes at once and never enters RUN.
                        done_d = 1'b1;
                    end
                end
            end
            default: begin
                // Abort takes priority over the terminal count and suppresses done.
                if (abort) begin
                    state_d = ST_IDLE;
                    cnt_d   = ZERO;
                end else if (enable) begin
                    if (cnt_q != ZERO) begin
                        cnt_d = cnt_q - ONE;
                    end else begin
                        done_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                        // Entry into RUN requires a nonzero length, so reload_q >= 1 here.
                        cnt_d = reload_q - ONE;
`else
                        state_d = ST_IDLE;
                        cnt_d   = ZERO;
`endif
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= ZERO;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reload_q <= ZERO;
        end else begin
            reload_q <= reload_d;
        end
    end
`endif

    assign load_ready = (state_q == ST_IDLE);
    assign busy       = (state_q == ST_RUN);
    assign done       = done_q;

endmodule

// File: tb/tb_countdown_yi_v1.sv
module tb_countdown_yi_v1;
    localparam int N = 20;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         load_valid = 1'b0;
    logic         load_ready;
    logic [N-1:0] load_number = '0;
    logic         enable = 1'b0;
    logic         abort = 1'b0;
    logic [N-1:0] cnt_q;
    logic         busy;
    logic         done;

    int checks = 0;
    int failures = 0;

    countdown_yi_v1 #(.BITS_OF_END_NUMBER(N)) dut (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
        .load_number(load_number), .enable(enable), .abort(abort),
        .cnt_q(cnt_q), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model. It tracks the number of enabled edges still needed before
    // completion, not the DUT's remaining-minus-one register.
    bit m_run;
    int m_left;
    int m_reload;
    bit m_done;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_run = 0; m_left = 0; m_reload = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (!m_run) begin
                if (load_valid) begin
                    m_reload = int'(load_number);
                    if (load_number == 0) m_done = 1;
                    else begin m_run = 1; m_left = int'(load_number); end
                end
            end else if (abort) begin
                m_run = 0; m_left = 0;
            end else if (enable) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_done = 1;
                    if (AR) m_left = m_reload;
                    else m_run = 0;
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (!reset) begin
            check("model_cnt", cnt_q, m_run ? m_left - 1 : 0);
            check("model_busy", busy, m_run);
            check("model_ready", load_ready, !m_run);
            check("model_done", done, m_done);
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input int num);
        load_valid = 1'b1; load_number = N'(num);
        cyc();
        load_valid = 1'b0;
    endtask

    int dcount;

    initial begin
        // Reset state
        cyc(2);
        check("rst_cnt", cnt_q, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", load_ready, 1);
        reset = 1'b0;
        cyc();

        // T1: load 5 with enable held high
        enable = 1'b1;
        load(5);
        check("t1_cnt_e0", cnt_q, 4);
        check("t1_busy", busy, 1);
        check("t1_ready", load_ready, 0);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            check("t1_cnt", cnt_q, 4 - i);
            check("t1_done_low", done, 0);
        end
        cyc();
        check("t1_done", done, 1);
        check("t1_idle_busy", busy, 0);
        check("t1_idle_ready", load_ready, 1);
        cyc();
        check("t1_done_1wide", done, 0);

        // T2: load 4, then enable 1,0,0,1,1,1
        load(4);
        check("t2_cnt_e0", cnt_q, 3);
        enable = 1; cyc(); check("t2_e1", cnt_q, 2);
        enable = 0; cyc(); check("t2_stall1", cnt_q, 2);
        cyc(); check("t2_stall2", cnt_q, 2);
        enable = 1; cyc(); check("t2_e4", cnt_q, 1);
        cyc(); check("t2_e5", cnt_q, 0);
        check("t2_nodone_yet", done, 0);
        cyc(); check("t2_done", done, 1);
        cyc();

        // T3: zero-length load; abort and enable must not matter in IDLE
        abort = 1; enable = 0;
        load(0);
        check("t3_done", done, 1);
        check("t3_busy", busy, 0);
        check("t3_cnt", cnt_q, 0);
        check("t3_ready", load_ready, 1);
        abort = 0;
        cyc();
        check("t3_done_1wide", done, 0);

        // T4: load 6, then abort at cnt_q == 2
        enable = 1;
        load(6);
        cyc(3);
        check("t4_cnt_pre", cnt_q, 2);
        abort = 1;
        cyc();
        abort = 0;
        check("t4_cnt", cnt_q, 0);
        check("t4_busy", busy, 0);
        check("t4_done", done, 0);
        dcount = 0;
        repeat (8) begin cyc(); if (done) dcount++; end
        check("t4_no_done", dcount, 0);

        // Abort coinciding with the terminal count suppresses done
        load(2);
        cyc();
        check("tc_cnt0", cnt_q, 0);
        abort = 1;
        cyc();
        abort = 0;
        check("tc_abort_done", done, 0);
        check("tc_abort_busy", busy, 0);
        cyc();

        // T5: load 3 with load_valid held (number 9) for the whole run
        load_valid = 1; load_number = 3;
        cyc();
        load_number = 9;
        check("t5_cnt_e0", cnt_q, 2);
        cyc(2);
        check("t5_cnt_e2", cnt_q, 0);
        if (AR) begin
            cyc();
            check("t5_ar_reload", cnt_q, 2);
            load_valid = 0;
            abort = 1; cyc(); abort = 0;
        end else begin
            cyc();
            check("t5_done", done, 1);
            check("t5_ready", load_ready, 1);
            cyc();
            load_valid = 0;
            check("t5_cnt9", cnt_q, 8);
            cyc(9);
            check("t5_done9", done, 1);
        end
        cyc();

        // Reset in the middle of a run
        load(7);
        cyc(2);
        reset = 1;
        #1;
        check("mr_cnt", cnt_q, 0);
        check("mr_busy", busy, 0);
        check("mr_ready", load_ready, 1);
        check("mr_done", done, 0);
        cyc();
        reset = 0;
        cyc();

`ifdef COUNTDOWN_AUTO_RELOAD_EN
        // T6: auto-reload with length 3, then length 1
        load(3);
        check("t6_cnt_e0", cnt_q, 2);
        cyc(2);
        check("t6_cnt0", cnt_q, 0);
        cyc();
        check("t6_done", done, 1);
        check("t6_reload", cnt_q, 2);
        check("t6_busy", busy, 1);
        cyc(3);
        check("t6_done2", done, 1);
        abort = 1; cyc(); abort = 0;
        check("t6_abort_busy", busy, 0);
        load(1);
        dcount = 0;
        repeat (4) begin cyc(); if (done) dcount++; end
        check("t6_n1_every", dcount, 4);
        reset = 1;
        #1;
        check("t6_rst_cnt", cnt_q, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_ready", load_ready, 1);
        check("t6_rst_done", done, 0);
        cyc();
        reset = 0;
        load(0);
        check("t6_zero_done", done, 1);
        check("t6_zero_busy", busy, 0);
        cyc();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
